fifo_push_arbiter: RTL and testbench

Round-robin arbiter and bit sequencer that shares the write side of the 1-bit serial FIFO between NUM_REQ byte-wide requesters.
- Grants one requester at a time and latches its word.
- Drives fifo_push/fifo_data LSB-first, one bit per cycle, stalling on fifo_full.
- Pulses ack to the owner when its last bit is pushed.
- Sits directly in front of the FIFO's push/data_in/full pins.

---
 rtl/fifo_push_arbiter_pkg.sv | 19 +
 rtl/fifo_push_arbiter_if.sv | 29 ++
 rtl/fifo_push_arbiter_rr_picker.sv | 32 +++
 rtl/fifo_push_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_push_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types and defaults for the fifo_push_arbiter slice.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_DATA_W  = 8;

  // Width of a requester index; never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_IDX_W = idx_w(DEF_NUM_REQ);

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Requester-side and FIFO-write-side signals of fifo_push_arbiter.
interface fifo_push_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DATA_W  = DEF_DATA_W
);
  localparam int unsigned IDX_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      busy;
  logic [IDX_W-1:0]          grant_id;
  logic                      fifo_full;
  logic                      fifo_push;
  logic                      fifo_data;

  modport master (
    input  req, req_data, fifo_full,
    output ack, busy, grant_id, fifo_push, fifo_data
  );

  modport slave (
    output req, req_data, fifo_full,
    input  ack, busy, grant_id, fifo_push, fifo_data
  );

endinterface

// File: rtl/fifo_push_arbiter_rr_picker.sv
// Combinational round-robin selector: first set req after last_i, wrapping.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   winner_o
);

  logic        found;
  int unsigned idx;

  assign any_o = |req_i;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_i) + k) % NUM_REQ;
      if (!found && req_i[idx]) begin
        winner_o = IDX_W'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter serialising requester words LSB-first into a 1-bit FIFO.
// Optional FIFO_ARB_PARITY_EN appends an even-parity bit after each word.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input logic                 clk,
  input logic                 rst_n,
  fifo_push_arbiter_if.master bus
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
`ifdef FIFO_ARB_PARITY_EN
  localparam int unsigned SH_W = DATA_W + 1;
`else
  localparam int unsigned SH_W = DATA_W;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SH_W - 1);

  arb_state_e         state_q, state_d;
  logic [SH_W-1:0]    shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   grant_q, grant_d;

  logic               any_req;
  logic [IDX_W-1:0]   winner;
  logic [DATA_W-1:0]  win_word;
  logic [SH_W-1:0]    load_word;
  logic               push;
  logic               data_bit;
  logic [NUM_REQ-1:0] ack_vec;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i    (bus.req),
    .last_i   (last_q),
    .any_o    (any_req),
    .winner_o (winner)
  );

  assign win_word = bus.req_data[winner*DATA_W +: DATA_W];

  // Parity rides as the top bit of the shift register so it falls out last.
`ifdef FIFO_ARB_PARITY_EN
  assign load_word = {^win_word, win_word};
`else
  assign load_word = win_word;
`endif

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    grant_d  = grant_q;
    push     = 1'b0;
    data_bit = 1'b0;
    ack_vec  = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          shreg_d = load_word;
          grant_d = winner;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        push     = !bus.fifo_full;
        data_bit = shreg_q[0];
        if (push) begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            ack_vec[grant_q] = 1'b1;
            last_d           = grant_q;
            state_d          = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  assign bus.fifo_push = push;
  assign bus.fifo_data = data_bit;
  assign bus.ack       = ack_vec;
  assign bus.busy      = (state_q == SEND);
  assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter against a bit-queue reference model.
module tb_fifo_push_arbiter;
  import fifo_arb_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;
`ifdef FIFO_ARB_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_push_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  fifo_push_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [N-1:0] req_v;
  logic [W-1:0] word_v [N];
  bit           hold_req;

  // Reference model: owner plus the queue of bits still to be pushed.
  bit m_busy;
  int m_owner, m_last, m_grant;
  bit m_bits[$];

  logic         lg_push[$], lg_data[$], lg_busy[$];
  logic [N-1:0] lg_ack[$];
  int           lg_grant[$];
  logic         ex_push[$], ex_data[$], ex_busy[$];
  logic [N-1:0] ex_ack[$];
  int           ex_grant[$];

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = N - 1;
    m_grant = 0;
    m_bits.delete();
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic full);
    if (m_busy) begin
      if (!full) begin
        void'(m_bits.pop_front());
        if (m_bits.size() == 0) begin
          m_busy = 1'b0;
          m_last = m_owner;
        end
      end
    end else if (r != '0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (r[c]) begin
          m_owner = c;
          break;
        end
      end
      m_grant = m_owner;
      m_bits.delete();
      for (int b = 0; b < W; b++) m_bits.push_back(word_v[m_owner][b]);
`ifdef FIFO_ARB_PARITY_EN
      m_bits.push_back(^word_v[m_owner]);
`endif
      m_busy = 1'b1;
    end
  endfunction

  task automatic clear_log();
    lg_push.delete(); lg_data.delete(); lg_busy.delete(); lg_ack.delete(); lg_grant.delete();
    ex_push.delete(); ex_data.delete(); ex_busy.delete(); ex_ack.delete(); ex_grant.delete();
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic cycle(input logic full);
    logic [N-1:0] ea;
    bus.req       = req_v;
    bus.fifo_full = full;
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = word_v[i];
    #4;
    lg_push.push_back(bus.fifo_push);
    lg_data.push_back(bus.fifo_data);
    lg_busy.push_back(bus.busy);
    lg_ack.push_back(bus.ack);
    lg_grant.push_back(int'(bus.grant_id));
    ea = '0;
    if (m_busy && !full && m_bits.size() == 1) ea[m_owner] = 1'b1;
    ex_push.push_back(m_busy && !full);
    ex_data.push_back(m_busy ? m_bits[0] : 1'b0);
    ex_busy.push_back(m_busy);
    ex_ack.push_back(ea);
    ex_grant.push_back(m_grant);
    model_step(req_v, full);
    if (!hold_req) req_v = req_v & ~bus.ack;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req_v    = '0;
    hold_req = 1'b0;
    bus.req  = '0;
    bus.fifo_full = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    req_v    = '0;
    hold_req = 1'b0;
    bus.req  = '1;
    bus.req_data  = '1;
    bus.fifo_full = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    if (bus.ack !== '0) begin errors++; $display("FAIL reset_ack: got %0h expected 0", bus.ack); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    checks++;
    if (bus.grant_id !== '0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", bus.grant_id); end
    checks++;
    if (bus.fifo_push !== 1'b0) begin errors++; $display("FAIL reset_push: got %0b expected 0", bus.fifo_push); end
    checks++;
    if (bus.fifo_data !== 1'b0) begin errors++; $display("FAIL reset_data: got %0b expected 0", bus.fifo_data); end
    checks++;
    bus.req = '0;
    rst_n   = 1'b1;
  endtask

  task automatic test_single();
    logic [W-1:0] w;
    logic eb, ep;
    logic [N-1:0] ea;
    w = 8'hA5;
    clear_log();
    word_v[0] = w;
    req_v = 4'b0001;
    for (int c = 0; c < NB + 2; c++) cycle(1'b0);
    for (int i = 0; i < NB + 2; i++) begin
      ep = (i >= 1 && i <= NB);
      ea = (i == NB) ? 4'b0001 : 4'b0000;
      if (lg_push[i] !== ep) begin errors++; $display("FAIL single_push[%0d]: got %0b expected %0b", i, lg_push[i], ep); end
      checks++;
      if (lg_busy[i] !== ep) begin errors++; $display("FAIL single_busy[%0d]: got %0b expected %0b", i, lg_busy[i], ep); end
      checks++;
      if (lg_ack[i] !== ea) begin errors++; $display("FAIL single_ack[%0d]: got %0h expected %0h", i, lg_ack[i], ea); end
      checks++;
      if (ep) begin
        eb = (i - 1 < W) ? w[i-1] : ^w;
        if (lg_data[i] !== eb) begin errors++; $display("FAIL single_data[%0d]: got %0b expected %0b", i, lg_data[i], eb); end
        checks++;
      end
    end
    if (lg_grant[1] !== 0) begin errors++; $display("FAIL single_grant: got %0d expected 0", lg_grant[1]); end
    checks++;
  endtask

  task automatic test_round_robin();
    int ids[$], at[$], exp_ids[2];
    bit bits[$], ebits[$];
    do_reset();
    for (int ph = 0; ph < 2; ph++) begin
      logic [W-1:0] wa, wb;
      int ia, ib;
      ia = 0;
      ib = (ph == 0) ? 2 : 1;
      exp_ids[0] = ia;
      exp_ids[1] = ib;
      wa = W'($urandom);
      wb = W'($urandom);
      word_v[ia] = wa;
      word_v[ib] = wb;
      clear_log();
      req_v = '0;
      req_v[ia] = 1'b1;
      req_v[ib] = 1'b1;
      for (int c = 0; c < 2*(NB+1) + 2; c++) cycle(1'b0);
      ids.delete(); at.delete(); bits.delete(); ebits.delete();
      for (int i = 0; i < lg_ack.size(); i++) begin
        if (lg_push[i]) bits.push_back(lg_data[i]);
        for (int b = 0; b < N; b++) if (lg_ack[i][b]) begin ids.push_back(b); at.push_back(i); end
      end
      for (int b = 0; b < W; b++) ebits.push_back(wa[b]);
`ifdef FIFO_ARB_PARITY_EN
      ebits.push_back(^wa);
`endif
      for (int b = 0; b < W; b++) ebits.push_back(wb[b]);
`ifdef FIFO_ARB_PARITY_EN
      ebits.push_back(^wb);
`endif
      if (ids.size() !== 2) begin
        errors++; $display("FAIL rr_ack_count[ph%0d]: got %0d expected 2", ph, ids.size());
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (ids[k] !== exp_ids[k]) begin errors++; $display("FAIL rr_order[ph%0d,%0d]: got %0d expected %0d", ph, k, ids[k], exp_ids[k]); end
          checks++;
          if (at[k] !== NB + k*(NB+1)) begin errors++; $display("FAIL rr_ack_cycle[ph%0d,%0d]: got %0d expected %0d", ph, k, at[k], NB + k*(NB+1)); end
          checks++;
        end
      end
      checks++;
      if (bits !== ebits) begin errors++; $display("FAIL rr_bits[ph%0d]: got %p expected %p", ph, bits, ebits); end
      checks++;
      if (lg_grant[NB+2] !== ib) begin errors++; $display("FAIL rr_grant[ph%0d]: got %0d expected %0d", ph, lg_grant[NB+2], ib); end
      checks++;
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w;
    bit bits[$], ebits[$];
    int ack_at;
    w = W'($urandom);
    word_v[3] = w;
    clear_log();
    req_v = 4'b1000;
    for (int c = 0; c < NB + 6; c++) cycle(c >= 4 && c <= 6);
    ack_at = -1;
    for (int i = 0; i < lg_push.size(); i++) begin
      if (lg_push[i]) bits.push_back(lg_data[i]);
      if (lg_ack[i] == 4'b1000) ack_at = i;
    end
    for (int c = 4; c <= 6; c++) begin
      if (lg_push[c] !== 1'b0 || lg_ack[c] !== '0) begin
        errors++; $display("FAIL bp_stall[%0d]: got push=%0b ack=%0h expected push=0 ack=0", c, lg_push[c], lg_ack[c]);
      end
      checks++;
    end
    for (int b = 0; b < W; b++) ebits.push_back(w[b]);
`ifdef FIFO_ARB_PARITY_EN
    ebits.push_back(^w);
`endif
    if (bits !== ebits) begin errors++; $display("FAIL bp_bits: got %p expected %p", bits, ebits); end
    checks++;
    if (ack_at !== NB + 3) begin errors++; $display("FAIL bp_ack_cycle: got %0d expected %0d", ack_at, NB + 3); end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w0;
    bit bits[$];
    clear_log();
    word_v[1] = W'($urandom);
    req_v = 4'b0010;
    for (int c = 0; c < 5; c++) cycle(1'b0);
    for (int i = 0; i < 5; i++) begin
      if (lg_ack[i] !== '0) begin errors++; $display("FAIL rm_early_ack[%0d]: got %0h expected 0", i, lg_ack[i]); end
      checks++;
    end
    rst_n = 1'b0;
    #1;
    if (bus.fifo_push !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== '0) begin
      errors++; $display("FAIL rm_async: got push=%0b busy=%0b ack=%0h expected 0,0,0", bus.fifo_push, bus.busy, bus.ack);
    end
    checks++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    clear_log();
    w0 = W'($urandom);
    word_v[0] = w0;
    req_v = 4'b0011;
    for (int c = 0; c < NB + 2; c++) cycle(1'b0);
    for (int i = 0; i < lg_push.size(); i++) if (lg_push[i]) bits.push_back(lg_data[i]);
    if (lg_ack[NB] !== 4'b0001) begin errors++; $display("FAIL rm_restart_ack: got %0h expected 1", lg_ack[NB]); end
    checks++;
    for (int b = 0; b < W; b++) begin
      if (bits.size() <= b || bits[b] !== w0[b]) begin
        errors++; $display("FAIL rm_restart_bit[%0d]: got %0b expected %0b", b, (bits.size() > b) ? bits[b] : 1'bx, w0[b]);
      end
      checks++;
    end
  endtask

  task automatic test_all_req();
    int ids[$], at[$];
    int exp_ids[5] = '{0, 1, 2, 3, 0};
    do_reset();
    clear_log();
    for (int i = 0; i < N; i++) word_v[i] = W'($urandom);
    hold_req = 1'b1;
    req_v = '1;
    for (int c = 0; c < 5*(NB+1) + 1; c++) cycle(1'b0);
    hold_req = 1'b0;
    for (int i = 0; i < lg_ack.size(); i++)
      for (int b = 0; b < N; b++) if (lg_ack[i][b]) begin ids.push_back(b); at.push_back(i); end
    if (ids.size() !== 5) begin
      errors++; $display("FAIL all_ack_count: got %0d expected 5", ids.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (ids[k] !== exp_ids[k]) begin errors++; $display("FAIL all_order[%0d]: got %0d expected %0d", k, ids[k], exp_ids[k]); end
        checks++;
        if (at[k] !== NB + k*(NB+1)) begin errors++; $display("FAIL all_ack_cycle[%0d]: got %0d expected %0d", k, at[k], NB + k*(NB+1)); end
        checks++;
      end
    end
    checks++;
  endtask

  task automatic test_random();
    int budget;
    do_reset();
    clear_log();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_v[i] && $urandom_range(0, 7) == 0) begin
          word_v[i] = W'($urandom);
          req_v[i]  = 1'b1;
        end
      cycle($urandom_range(0, 3) == 0);
    end
    budget = 0;
    while ((req_v != '0 || m_busy) && budget < 200) begin
      cycle(1'b0);
      budget++;
    end
    if (req_v != '0 || m_busy) begin errors++; $display("FAIL rnd_drain: got pending req=%0h expected all served within 200 cycles", req_v); end
    checks++;
    for (int i = 0; i < lg_push.size(); i++) begin
      if (lg_push[i] !== ex_push[i]) begin errors++; $display("FAIL rnd_push[%0d]: got %0b expected %0b", i, lg_push[i], ex_push[i]); end
      checks++;
      if (lg_data[i] !== ex_data[i]) begin errors++; $display("FAIL rnd_data[%0d]: got %0b expected %0b", i, lg_data[i], ex_data[i]); end
      checks++;
      if (lg_ack[i] !== ex_ack[i]) begin errors++; $display("FAIL rnd_ack[%0d]: got %0h expected %0h", i, lg_ack[i], ex_ack[i]); end
      checks++;
      if (lg_busy[i] !== ex_busy[i]) begin errors++; $display("FAIL rnd_busy[%0d]: got %0b expected %0b", i, lg_busy[i], ex_busy[i]); end
      checks++;
      if (lg_grant[i] !== ex_grant[i]) begin errors++; $display("FAIL rnd_grant[%0d]: got %0d expected %0d", i, lg_grant[i], ex_grant[i]); end
      checks++;
    end
  endtask

`ifdef FIFO_ARB_PARITY_EN
  task automatic test_parity();
    int pushes;
    bit last_bit;
    int ack_at;
    clear_log();
    word_v[0] = 8'h07;
    req_v = 4'b0001;
    for (int c = 0; c < NB + 2; c++) cycle(1'b0);
    pushes = 0;
    last_bit = 1'b0;
    ack_at = -1;
    for (int i = 0; i < lg_push.size(); i++) begin
      if (lg_push[i]) begin pushes++; last_bit = lg_data[i]; end
      if (lg_ack[i] == 4'b0001) ack_at = i;
    end
    if (pushes !== 9) begin errors++; $display("FAIL par_pushes: got %0d expected 9", pushes); end
    checks++;
    if (last_bit !== 1'b1) begin errors++; $display("FAIL par_bit: got %0b expected 1", last_bit); end
    checks++;
    if (ack_at !== 9) begin errors++; $display("FAIL par_ack_cycle: got %0d expected 9", ack_at); end
    checks++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) word_v[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_all_req();
    test_random();
`ifdef FIFO_ARB_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
